mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like memory port between the CPU's instruction-fetch requester and its data (load/store) requester.
- Serialises the two requesters, with at most one outstanding transaction at any time.
- Uses round-robin priority, with the data side preferred first after reset.
- Discards instruction responses invalidated by an exception flush.
- Sits between the CPU core and the cache/AXI bridge.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the instruction, data and shared-memory handshakes of mem_port_arbiter.
// The arbiter connects through slave; the core/memory side connects through master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  flush, inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, busy
    );

    modport master (
        output flush, inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM-like port between instruction fetch and data access,
// one transaction outstanding at a time; flushed instruction responses are swallowed.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    state_t            r_state;
    logic              r_last_data;
    logic              r_drop;
    logic              r_mem_req;
    logic              r_mem_wr;
    logic [3:0]        r_mem_wstrb;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_inst_want;
    logic              w_grant_data;
    logic              w_grant_inst;
    logic              w_inst_addr_ok;
    logic              w_inst_data_ok;
    logic              w_data_addr_ok;
    logic              w_data_data_ok;

    // An instruction request is invisible to arbitration while flush is high.
    always_comb begin
        w_inst_want  = bus.inst_req && !bus.flush;
        w_grant_data = bus.data_req && (!w_inst_want || !r_last_data);
        w_grant_inst = w_inst_want && !w_grant_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_data <= 1'b0;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_data) begin
                        r_state     <= D_ADDR;
                        r_last_data <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= bus.data_wr;
                        r_mem_wstrb <= bus.data_wr ? bus.data_wstrb : 4'b0000;
                        r_mem_addr  <= bus.data_addr;
                        r_mem_wdata <= bus.data_wdata;
                    end else if (w_grant_inst) begin
                        r_state     <= I_ADDR;
                        r_last_data <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_wstrb <= '0;
                        r_mem_addr  <= bus.inst_addr;
                        r_mem_wdata <= '0;
                    end
                end
                I_ADDR: begin
                    if (bus.flush) r_drop <= 1'b1;
                    if (bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= I_DATA;
                    end
                end
                I_DATA: begin
                    if (bus.flush) r_drop <= 1'b1;
                    if (bus.mem_data_ok) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                D_ADDR: begin
                    if (bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= D_DATA;
                    end
                end
                D_DATA: begin
                    if (bus.mem_data_ok) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_inst_addr_ok = (r_state == I_ADDR) && bus.mem_addr_ok;
        w_inst_data_ok = (r_state == I_DATA) && bus.mem_data_ok && !r_drop;
        w_data_addr_ok = (r_state == D_ADDR) && bus.mem_addr_ok;
        w_data_data_ok = (r_state == D_DATA) && bus.mem_data_ok;
    end

    assign bus.inst_addr_ok = w_inst_addr_ok;
    assign bus.inst_data_ok = w_inst_data_ok;
    assign bus.inst_rdata   = w_inst_data_ok ? bus.mem_rdata : '0;
    assign bus.data_addr_ok = w_data_addr_ok;
    assign bus.data_data_ok = w_data_data_ok;
    assign bus.data_rdata   = w_data_data_ok ? bus.mem_rdata : '0;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_wr       = r_mem_wr;
    assign bus.mem_wstrb    = r_mem_wstrb;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: two requester drivers, a memory responder
// with a round-robin reference model, and a monitor popping expected responses.
module tb_mem_port_arbiter;
    localparam int N      = 40;
    localparam int NONE   = 0;
    localparam int OWN_I  = 1;
    localparam int OWN_D  = 2;

    typedef struct {
        logic [31:0] rdata;
        bit          drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        inst_q[$];
    logic [31:0] data_q[$];
    int          n_inst_done = 0;
    int          n_data_done = 0;
    bit          auto_mem;
    bit          mon_en;
    bit          stop;
    logic        man_aok, man_dok;
    logic [31:0] man_rdata;
    int          owner;
    bit          tb_busy;
    int          last_grant;

    logic        s_inst_req, s_data_req, s_data_wr;
    logic [31:0] s_inst_addr, s_data_addr, s_data_wdata;
    logic [3:0]  s_data_wstrb;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic inst_drv(input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          t;
            bit          plan;
            logic [31:0] a;
            exp_t        e;
            gap = (i == 0) ? 0 : int'($urandom_range(0, 3));
            repeat (gap) begin @(posedge clk); #1; end
            if (i == 0)      a = 32'hBFC0_0000;
            else if (i == 1) a = 32'hBFC0_0010;
            else             a = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
            plan = (i == 1) || (i > 1 && $urandom_range(0, 3) == 0);
            e.rdata = mem_fn(a);
            e.drop  = plan;
            inst_q.push_back(e);
            bus.inst_addr = a;
            bus.inst_req  = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.inst_addr_ok && t < 200);
            chk("inst_accept", bus.inst_addr_ok, 1);
            @(posedge clk); #1;
            bus.inst_req  = 1'b0;
            bus.inst_addr = $urandom;
            if (plan) begin
                bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.flush = 1'b0;
            end
        end
    endtask

    task automatic data_drv(input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          t;
            logic [31:0] a;
            gap = (i == 0) ? 0 : int'($urandom_range(0, 3));
            repeat (gap) begin @(posedge clk); #1; end
            if (i == 0) begin
                a = 32'h8000_1000;
                bus.data_wr = 1'b1; bus.data_wstrb = 4'hF; bus.data_wdata = 32'hDEAD_BEEF;
            end else if (i == 1) begin
                a = 32'h8000_0002;
                bus.data_wr = 1'b1; bus.data_wstrb = 4'h4; bus.data_wdata = $urandom;
            end else begin
                a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
                bus.data_wr    = $urandom_range(0, 1) == 1;
                bus.data_wstrb = 4'($urandom_range(0, 15));
                bus.data_wdata = $urandom;
            end
            data_q.push_back(mem_fn(a));
            bus.data_addr = a;
            bus.data_req  = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.data_addr_ok && t < 200);
            chk("data_accept", bus.data_addr_ok, 1);
            @(posedge clk); #1;
            bus.data_req = 1'b0;
        end
    endtask

    // Memory responder plus round-robin reference: owner chosen from requests held at the grant edge.
    task automatic mem_model();
        while (!stop) begin
            @(posedge clk); #1;
            if (!auto_mem) begin
                bus.mem_addr_ok = man_aok;
                bus.mem_data_ok = man_dok;
                bus.mem_rdata   = man_rdata;
            end else if (!rst) begin
                bus.mem_rdata = $urandom;
                if (bus.mem_req) begin
                    int          k;
                    int          d;
                    int          eo;
                    logic [31:0] ea;
                    chk("grant_had_request", s_inst_req | s_data_req, 1);
                    if (s_inst_req && s_data_req) eo = (last_grant == OWN_I) ? OWN_D : OWN_I;
                    else                          eo = s_data_req ? OWN_D : OWN_I;
                    last_grant = eo;
                    owner      = eo;
                    tb_busy    = 1'b1;
                    if (eo == OWN_I) begin
                        ea = s_inst_addr;
                        chk("inst_mem_addr", bus.mem_addr, ea);
                        chk("inst_mem_wr", bus.mem_wr, 0);
                        chk("inst_mem_wstrb", bus.mem_wstrb, 0);
                    end else begin
                        ea = s_data_addr;
                        chk("data_mem_addr", bus.mem_addr, ea);
                        chk("data_mem_wr", bus.mem_wr, s_data_wr);
                        chk("data_mem_wstrb", bus.mem_wstrb, s_data_wr ? s_data_wstrb : 4'h0);
                        if (s_data_wr) chk("data_mem_wdata", bus.mem_wdata, s_data_wdata);
                    end
                    k = $urandom_range(0, 3);
                    repeat (k) begin
                        @(posedge clk); #1;
                        bus.mem_rdata = $urandom;
                        chk("mem_req_held", bus.mem_req, 1);
                        chk("mem_addr_stable", bus.mem_addr, ea);
                    end
                    bus.mem_addr_ok = 1'b1;
                    @(posedge clk); #1;
                    bus.mem_addr_ok = 1'b0;
                    chk("mem_req_dropped", bus.mem_req, 0);
                    d = $urandom_range(1, 3);
                    repeat (d) begin @(posedge clk); #1; bus.mem_rdata = $urandom; end
                    bus.mem_data_ok = 1'b1;
                    bus.mem_rdata   = mem_fn(ea);
                    @(posedge clk); #1;
                    bus.mem_data_ok = 1'b0;
                    bus.mem_rdata   = $urandom;
                    tb_busy = 1'b0;
                    owner   = NONE;
                end else if (s_inst_req || s_data_req) begin
                    chk("grant_latency", bus.mem_req, 1);
                end
            end
        end
    endtask

    task automatic monitor();
        while (!stop) begin
            @(negedge clk);
            s_inst_req   = bus.inst_req;
            s_inst_addr  = bus.inst_addr;
            s_data_req   = bus.data_req;
            s_data_wr    = bus.data_wr;
            s_data_wstrb = bus.data_wstrb;
            s_data_addr  = bus.data_addr;
            s_data_wdata = bus.data_wdata;
            if (mon_en && !rst) begin
                chk("busy", bus.busy, tb_busy);
                chk("inst_addr_ok", bus.inst_addr_ok, bus.mem_addr_ok && owner == OWN_I);
                chk("data_addr_ok", bus.data_addr_ok, bus.mem_addr_ok && owner == OWN_D);
                if (bus.mem_data_ok && owner == OWN_I) begin
                    chk("inst_q_avail", inst_q.size() != 0, 1);
                    if (inst_q.size() != 0) begin
                        exp_t e;
                        e = inst_q.pop_front();
                        n_inst_done++;
                        chk("inst_data_ok", bus.inst_data_ok, !e.drop);
                        chk("inst_rdata", bus.inst_rdata, e.drop ? 32'h0 : e.rdata);
                    end
                end else begin
                    chk("inst_data_ok_idle", bus.inst_data_ok, 0);
                    chk("inst_rdata_idle", bus.inst_rdata, 0);
                end
                if (bus.mem_data_ok && owner == OWN_D) begin
                    chk("data_q_avail", data_q.size() != 0, 1);
                    if (data_q.size() != 0) begin
                        logic [31:0] r;
                        r = data_q.pop_front();
                        n_data_done++;
                        chk("data_data_ok", bus.data_data_ok, 1);
                        chk("data_rdata", bus.data_rdata, r);
                    end
                end else begin
                    chk("data_data_ok_idle", bus.data_data_ok, 0);
                    chk("data_rdata_idle", bus.data_rdata, 0);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        auto_mem = 1'b1; mon_en = 1'b0; stop = 1'b0;
        man_aok = 1'b0; man_dok = 1'b0; man_rdata = '0;
        owner = NONE; tb_busy = 1'b0; last_grant = OWN_I;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_oks", {bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok}, 0);

        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        fork
            begin
                int t;
                fork
                    inst_drv(N);
                    data_drv(N);
                join
                t = 0;
                while ((tb_busy || inst_q.size() != 0 || data_q.size() != 0) && t < 300) begin
                    @(negedge clk); t++;
                end
                chk("drain_busy", tb_busy, 0);
                chk("inst_q_empty", inst_q.size(), 0);
                chk("data_q_empty", data_q.size(), 0);
                chk("inst_done", n_inst_done, N);
                chk("data_done", n_data_done, N);

                // Reset during a data response phase, then a stray response after reset.
                @(negedge clk);
                auto_mem = 1'b0;
                mon_en   = 1'b0;
                @(posedge clk); #1;
                bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h8000_2000;
                t = 0;
                do begin
                    @(negedge clk); t++;
                    if (bus.mem_req) man_aok = 1'b1;
                end while (!bus.data_addr_ok && t < 50);
                chk("rst_test_accept", bus.data_addr_ok, 1);
                man_aok = 1'b0;
                @(posedge clk); #1;
                bus.data_req = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                man_dok   = 1'b1;
                man_rdata = 32'hCAFE_F00D;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("post_rst_mem_data_ok_seen", bus.mem_data_ok, 1);
                chk("post_rst_data_data_ok", bus.data_data_ok, 0);
                chk("post_rst_data_rdata", bus.data_rdata, 0);
                chk("post_rst_inst_data_ok", bus.inst_data_ok, 0);
                chk("post_rst_mem_req", bus.mem_req, 0);
                chk("post_rst_busy", bus.busy, 0);
                man_dok = 1'b0;
                man_aok = 1'b1;
                @(negedge clk);
                chk("stray_data_addr_ok", bus.data_addr_ok, 0);
                chk("stray_inst_addr_ok", bus.inst_addr_ok, 0);
                chk("stray_busy", bus.busy, 0);
                man_aok = 1'b0;
                @(negedge clk);
                stop = 1'b1;
            end
            mem_model();
            monitor();
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
